// File: rtl/ex_stage.sv
// Execute stage: ALU, carry/zero flags, branch resolution and the EX/MEM register (falling-edge state).
// Optional EX_PERF_CNT_EN adds retired/mispredict counters perf_retired and perf_mispred.
module ex_stage #(
  parameter int         DATA_W = 16,
  parameter logic [2:0] NOP_OP = 3'b111
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_pc,
  input  logic              in_lhi,
  input  logic [DATA_W-1:0] in_m_addr,
  input  logic [DATA_W-1:0] in_src0,
  input  logic [DATA_W-1:0] in_src1,
  input  logic [1:0]        in_lm_start,
  input  logic [DATA_W-1:0] in_data_in,
  input  logic [2:0]        in_rdest,
  input  logic [2:0]        in_alu_op,
  input  logic              in_mem_ans,
  input  logic              in_w_mem,
  input  logic              in_w_reg,
  input  logic [1:0]        in_jump,
  input  logic              in_stop,
  input  logic              in_bpr,
  input  logic              stall_mem,
  output logic              stall_ex,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_result,
  output logic [DATA_W-1:0] out_m_addr,
  output logic [DATA_W-1:0] out_data_in,
  output logic [1:0]        out_lm_start,
  output logic [2:0]        out_rdest,
  output logic              out_mem_ans,
  output logic              out_w_mem,
  output logic              out_w_reg,
  output logic              out_stop,
  output logic              flag_c,
  output logic              flag_z,
  output logic              flush_out,
  output logic [DATA_W-1:0] redirect_pc,
`ifdef EX_PERF_CNT_EN
  output logic [15:0]       perf_retired,
  output logic [15:0]       perf_mispred,
`endif
  output logic              halted
);

  localparam logic [DATA_W-1:0] ONE = 1;

  logic              valid_q, wMem_q, wReg_q, stop_q, memAns_q;
  logic [DATA_W-1:0] pc_q, result_q, mAddr_q, dataIn_q, redirect_q;
  logic [1:0]        lmStart_q;
  logic [2:0]        rdest_q;
  logic              flagC_q, flagZ_q, flush_q, halted_q;

  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] pcInc, aluRes, result_d, target, redirect_d;
  logic              setC, setZ, taken, mispred, flagC_d, flagZ_d;
  logic              capture, accept;

  always_comb begin
    sum     = {1'b0, in_src0} + {1'b0, in_src1};
    pcInc   = in_pc + ONE;
    aluRes  = '0;
    setC    = 1'b0;
    setZ    = 1'b0;
    case (in_alu_op)
      3'b000: begin aluRes = sum[DATA_W-1:0]; setC = 1'b1; setZ = 1'b1; end
      3'b001: begin aluRes = ~(in_src0 & in_src1); setZ = 1'b1; end
      3'b010: begin aluRes = in_src0 - in_src1; setZ = 1'b1; end
      3'b011: aluRes = sum[DATA_W-1:0];
      3'b100: aluRes = in_src1;
      NOP_OP: aluRes = '0;
      default: aluRes = '0;
    endcase

    result_d = aluRes;
    if (in_lhi) begin
      result_d = {in_src1[8:0], 7'b0};
      setC     = 1'b0;
      setZ     = 1'b0;
    end

    // Link-writing jumps replace the ALU result with the return address.
    taken  = 1'b0;
    target = in_m_addr;
    case (in_jump)
      2'b01: taken = (in_src0 == in_src1);
      2'b10: begin taken = 1'b1; result_d = pcInc; end
      2'b11: begin taken = 1'b1; target = in_src1; result_d = pcInc; end
      default: taken = 1'b0;
    endcase

    mispred    = (taken != in_bpr);
    redirect_d = taken ? target : pcInc;
    flagC_d    = setC ? sum[DATA_W] : flagC_q;
    flagZ_d    = setZ ? (result_d == '0) : flagZ_q;
  end

  // An entry arriving right behind a flush is the wrong-path instruction.
  assign capture = !stall_mem && !halted_q;
  assign accept  = capture && in_valid && !flush_q;

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      result_q   <= '0;
      mAddr_q    <= '0;
      dataIn_q   <= '0;
      lmStart_q  <= '0;
      rdest_q    <= '0;
      memAns_q   <= 1'b0;
      wMem_q     <= 1'b0;
      wReg_q     <= 1'b0;
      stop_q     <= 1'b0;
      flagC_q    <= 1'b0;
      flagZ_q    <= 1'b0;
      flush_q    <= 1'b0;
      redirect_q <= '0;
      halted_q   <= 1'b0;
    end else begin
      flush_q <= accept && mispred;
      if (accept) begin
        valid_q   <= 1'b1;
        pc_q      <= in_pc;
        result_q  <= result_d;
        mAddr_q   <= in_m_addr;
        dataIn_q  <= in_data_in;
        lmStart_q <= in_lm_start;
        rdest_q   <= in_rdest;
        memAns_q  <= in_mem_ans;
        wMem_q    <= in_w_mem;
        wReg_q    <= in_w_reg;
        stop_q    <= in_stop;
        flagC_q   <= flagC_d;
        flagZ_q   <= flagZ_d;
        if (mispred) redirect_q <= redirect_d;
        if (in_stop) halted_q <= 1'b1;
      end else if (capture) begin
        valid_q <= 1'b0;
        wMem_q  <= 1'b0;
        wReg_q  <= 1'b0;
        stop_q  <= 1'b0;
      end
    end
  end

`ifdef EX_PERF_CNT_EN
  logic [15:0] perfRetired_q, perfMispred_q;

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      perfRetired_q <= '0;
      perfMispred_q <= '0;
    end else if (accept) begin
      perfRetired_q <= perfRetired_q + 16'd1;
      if (mispred) perfMispred_q <= perfMispred_q + 16'd1;
    end
  end

  assign perf_retired = perfRetired_q;
  assign perf_mispred = perfMispred_q;
`endif

  assign stall_ex     = stall_mem || halted_q;
  assign out_valid    = valid_q;
  assign out_pc       = pc_q;
  assign out_result   = result_q;
  assign out_m_addr   = mAddr_q;
  assign out_data_in  = dataIn_q;
  assign out_lm_start = lmStart_q;
  assign out_rdest    = rdest_q;
  assign out_mem_ans  = memAns_q;
  assign out_w_mem    = wMem_q;
  assign out_w_reg    = wReg_q;
  assign out_stop     = stop_q;
  assign flag_c       = flagC_q;
  assign flag_z       = flagZ_q;
  assign flush_out    = flush_q;
  assign redirect_pc  = redirect_q;
  assign halted       = halted_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios plus random entries against a behavioural model.
// Define EX_PERF_CNT_EN for both files to also exercise the performance counters.
module tb_ex_stage;

  logic        clk;
  logic        reset;
  logic        in_valid, in_lhi, in_mem_ans, in_w_mem, in_w_reg, in_stop, in_bpr, stall_mem;
  logic [15:0] in_pc, in_m_addr, in_src0, in_src1, in_data_in;
  logic [1:0]  in_lm_start, in_jump;
  logic [2:0]  in_rdest, in_alu_op;
  logic        stall_ex, out_valid, out_mem_ans, out_w_mem, out_w_reg, out_stop;
  logic [15:0] out_pc, out_result, out_m_addr, out_data_in, redirect_pc;
  logic [1:0]  out_lm_start;
  logic [2:0]  out_rdest;
  logic        flag_c, flag_z, flush_out, halted;
`ifdef EX_PERF_CNT_EN
  logic [15:0] perf_retired, perf_mispred;
`endif

  int checks = 0;
  int errors = 0;

  ex_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_pc(in_pc), .in_lhi(in_lhi), .in_m_addr(in_m_addr),
    .in_src0(in_src0), .in_src1(in_src1), .in_lm_start(in_lm_start), .in_data_in(in_data_in),
    .in_rdest(in_rdest), .in_alu_op(in_alu_op), .in_mem_ans(in_mem_ans), .in_w_mem(in_w_mem),
    .in_w_reg(in_w_reg), .in_jump(in_jump), .in_stop(in_stop), .in_bpr(in_bpr),
    .stall_mem(stall_mem), .stall_ex(stall_ex), .out_valid(out_valid), .out_pc(out_pc),
    .out_result(out_result), .out_m_addr(out_m_addr), .out_data_in(out_data_in),
    .out_lm_start(out_lm_start), .out_rdest(out_rdest), .out_mem_ans(out_mem_ans),
    .out_w_mem(out_w_mem), .out_w_reg(out_w_reg), .out_stop(out_stop),
    .flag_c(flag_c), .flag_z(flag_z), .flush_out(flush_out), .redirect_pc(redirect_pc),
`ifdef EX_PERF_CNT_EN
    .perf_retired(perf_retired), .perf_mispred(perf_mispred),
`endif
    .halted(halted)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  // Architectural view of the stage: what EX/MEM, flags and control should hold.
  logic        mValid, mMemAns, mWmem, mWreg, mStop, mC, mZ, mFlush, mHalted;
  logic [15:0] mPc, mResult, mMaddr, mData, mRedirect;
  logic [1:0]  mLm;
  logic [2:0]  mRdest;
  int          mRetired, mMispred;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    {mValid, mMemAns, mWmem, mWreg, mStop, mC, mZ, mFlush, mHalted} = '0;
    {mPc, mResult, mMaddr, mData, mRedirect} = '0;
    mLm = '0; mRdest = '0; mRetired = 0; mMispred = 0;
  endtask

  task automatic modelEdge();
    int  a, b, pcNext, res, tgt;
    bit  taken, newFlush;
    a = int'(in_src0); b = int'(in_src1);
    pcNext = (int'(in_pc) + 1) % 65536;
    newFlush = 1'b0;
    if (!stall_mem && !mHalted) begin
      if (in_valid && !mFlush) begin
        res = 0;
        if (in_lhi) res = (b % 512) * 128;
        else case (in_alu_op)
          3'd0: begin res = (a + b) % 65536; mC = (a + b) > 65535; mZ = (res == 0); end
          3'd1: begin res = (~(a & b)) & 32'hFFFF; mZ = (res == 0); end
          3'd2: begin res = (a - b + 65536) % 65536; mZ = (res == 0); end
          3'd3: res = (a + b) % 65536;
          3'd4: res = b;
          default: res = 0;
        endcase
        taken = 1'b0; tgt = int'(in_m_addr);
        if (in_jump == 2'd1) taken = (a == b);
        if (in_jump == 2'd2) begin taken = 1'b1; res = pcNext; end
        if (in_jump == 2'd3) begin taken = 1'b1; tgt = b; res = pcNext; end
        mValid = 1'b1; mPc = in_pc; mResult = res[15:0]; mMaddr = in_m_addr;
        mData = in_data_in; mLm = in_lm_start; mRdest = in_rdest; mMemAns = in_mem_ans;
        mWmem = in_w_mem; mWreg = in_w_reg; mStop = in_stop;
        mRetired = (mRetired + 1) % 65536;
        if (taken != in_bpr) begin
          newFlush = 1'b1;
          mRedirect = taken ? tgt[15:0] : pcNext[15:0];
          mMispred = (mMispred + 1) % 65536;
        end
        if (in_stop) mHalted = 1'b1;
      end else begin
        mValid = 1'b0; mWmem = 1'b0; mWreg = 1'b0; mStop = 1'b0;
      end
    end
    mFlush = newFlush;
  endtask

  task automatic compareAll();
    checkOutput("out_valid", out_valid, mValid);
    checkOutput("out_pc", out_pc, mPc);
    checkOutput("out_result", out_result, mResult);
    checkOutput("out_m_addr", out_m_addr, mMaddr);
    checkOutput("out_data_in", out_data_in, mData);
    checkOutput("out_lm_start", out_lm_start, mLm);
    checkOutput("out_rdest", out_rdest, mRdest);
    checkOutput("out_mem_ans", out_mem_ans, mMemAns);
    checkOutput("out_w_mem", out_w_mem, mWmem);
    checkOutput("out_w_reg", out_w_reg, mWreg);
    checkOutput("out_stop", out_stop, mStop);
    checkOutput("flag_c", flag_c, mC);
    checkOutput("flag_z", flag_z, mZ);
    checkOutput("flush_out", flush_out, mFlush);
    // redirect_pc only carries meaning while a flush is being signalled
    if (mFlush) checkOutput("redirect_pc", redirect_pc, mRedirect);
    checkOutput("halted", halted, mHalted);
    checkOutput("stall_ex", stall_ex, stall_mem | mHalted);
`ifdef EX_PERF_CNT_EN
    checkOutput("perf_retired", perf_retired, mRetired[15:0]);
    checkOutput("perf_mispred", perf_mispred, mMispred[15:0]);
`endif
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] pc, input logic [15:0] a,
                               input logic [15:0] b, input logic [2:0] op, input logic [1:0] jmp,
                               input logic [15:0] maddr, input logic bpr, input logic lhi,
                               input logic stop);
    in_valid = v; in_pc = pc; in_src0 = a; in_src1 = b; in_alu_op = op; in_jump = jmp;
    in_m_addr = maddr; in_bpr = bpr; in_lhi = lhi; in_stop = stop;
    in_data_in = 16'($urandom); in_lm_start = 2'($urandom); in_rdest = 3'($urandom);
    in_mem_ans = 1'($urandom); in_w_mem = 1'($urandom); in_w_reg = 1'($urandom);
  endtask

  task automatic advance();
    @(negedge clk);
    modelEdge();
    #2;
    compareAll();
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    #1;
    modelReset();
    compareAll();
    #1 reset = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0]  op;
    logic [1:0]  jmp;
    logic [15:0] a, b;
    reset = 1'b1; stall_mem = 1'b0;
    applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 3'b111, 2'b00, 16'h0, 1'b0, 1'b0, 1'b0);
    modelReset();
    #12 reset = 1'b0;
    compareAll();

    // Build non-zero state, stall, then reset while stalled.
    applyStimulus(1'b1, 16'h0010, 16'h0003, 16'h0004, 3'b000, 2'b00, 16'h0077, 1'b0, 1'b0, 1'b0);
    advance();
    stall_mem = 1'b1;
    advance();
    #1 pulseReset();
    checkOutput("rst_halted", halted, 16'h0);
    checkOutput("rst_result", out_result, 16'h0);
    stall_mem = 1'b0;

    // ADD producing carry out and zero, then NAND keeping carry.
    applyStimulus(1'b1, 16'h0020, 16'hFFFF, 16'h0001, 3'b000, 2'b00, 16'h0, 1'b0, 1'b0, 1'b0);
    advance();
    checkOutput("add_res", out_result, 16'h0000);
    checkOutput("add_c", flag_c, 16'h1);
    checkOutput("add_z", flag_z, 16'h1);
    applyStimulus(1'b1, 16'h0021, 16'hFFFF, 16'hFFFF, 3'b001, 2'b00, 16'h0, 1'b0, 1'b0, 1'b0);
    advance();
    checkOutput("nand_res", out_result, 16'h0000);
    checkOutput("nand_c", flag_c, 16'h1);
    checkOutput("nand_z", flag_z, 16'h1);

    // BEQ taken but predicted not-taken; the following entry is squashed.
    applyStimulus(1'b1, 16'h0030, 16'h0005, 16'h0005, 3'b111, 2'b01, 16'h0040, 1'b0, 1'b0, 1'b0);
    advance();
    checkOutput("beq_flush", flush_out, 16'h1);
    checkOutput("beq_redir", redirect_pc, 16'h0040);
    applyStimulus(1'b1, 16'h0031, 16'h0001, 16'h0002, 3'b000, 2'b00, 16'h0, 1'b0, 1'b0, 1'b0);
    advance();
    checkOutput("squash_valid", out_valid, 16'h0);
    checkOutput("squash_flush", flush_out, 16'h0);

    // JAL correctly predicted, then JLR wrapping pc+1 and mispredicted.
    applyStimulus(1'b1, 16'h00FF, 16'h0000, 16'h0000, 3'b111, 2'b10, 16'h0200, 1'b1, 1'b0, 1'b0);
    advance();
    checkOutput("jal_res", out_result, 16'h0100);
    checkOutput("jal_flush", flush_out, 16'h0);
    applyStimulus(1'b1, 16'hFFFF, 16'h0000, 16'h1234, 3'b111, 2'b11, 16'h0200, 1'b0, 1'b0, 1'b0);
    advance();
    checkOutput("jlr_res", out_result, 16'h0000);
    checkOutput("jlr_flush", flush_out, 16'h1);
    checkOutput("jlr_redir", redirect_pc, 16'h1234);
    applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 3'b111, 2'b00, 16'h0, 1'b0, 1'b0, 1'b0);
    advance();

    // Random traffic with occasional stalls; no stop instructions here.
    for (int i = 0; i < 300; i++) begin
      op  = 3'($urandom);
      jmp = 2'($urandom);
      a   = 16'($urandom);
      b   = ($urandom_range(0, 1) == 0) ? a : 16'($urandom);
      if ($urandom_range(0, 5) == 0) a = 16'hFFFF - b + 16'($urandom_range(0, 2));
      if (jmp[1]) op = 3'b111;
      applyStimulus(($urandom_range(0, 3) != 0), 16'($urandom), a, b, op, jmp, 16'($urandom),
                    1'($urandom), (!jmp[1] && $urandom_range(0, 7) == 0), 1'b0);
      stall_mem = ($urandom_range(0, 4) == 0);
      advance();
    end
    stall_mem = 1'b0;

`ifdef EX_PERF_CNT_EN
    // Ten valid entries, two of them mispredicted BEQs each followed by an idle slot.
    #1 pulseReset();
    for (int i = 0; i < 12; i++) begin
      if (i == 2 || i == 7)
        applyStimulus(1'b1, 16'(i), 16'h0009, 16'h0009, 3'b111, 2'b01, 16'h0100, 1'b0, 1'b0, 1'b0);
      else if (i == 3 || i == 8)
        applyStimulus(1'b0, 16'(i), 16'h0, 16'h0, 3'b111, 2'b00, 16'h0, 1'b0, 1'b0, 1'b0);
      else
        applyStimulus(1'b1, 16'(i), 16'(i), 16'h0001, 3'b000, 2'b00, 16'h0, 1'b0, 1'b0, 1'b0);
      advance();
    end
    checkOutput("perf_retired10", perf_retired, 16'd10);
    checkOutput("perf_mispred2", perf_mispred, 16'd2);
`endif

    // Three stalled edges hold everything, then a stop entry halts the stage.
    applyStimulus(1'b1, 16'h0050, 16'h0001, 16'h0002, 3'b000, 2'b00, 16'h0, 1'b0, 1'b0, 1'b0);
    advance();
    applyStimulus(1'b1, 16'h0051, 16'h1111, 16'h2222, 3'b000, 2'b00, 16'h0, 1'b0, 1'b0, 1'b0);
    stall_mem = 1'b1;
    for (int i = 0; i < 3; i++) begin
      advance();
      checkOutput("stall_pc", out_pc, 16'h0050);
      checkOutput("stall_res", out_result, 16'h0003);
    end
    stall_mem = 1'b0;
    applyStimulus(1'b1, 16'h0060, 16'h0000, 16'h0000, 3'b111, 2'b00, 16'h0, 1'b0, 1'b0, 1'b1);
    advance();
    checkOutput("stop_out", out_stop, 16'h1);
    checkOutput("stop_valid", out_valid, 16'h1);
    checkOutput("stop_halted", halted, 16'h1);
    checkOutput("stop_stall_ex", stall_ex, 16'h1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 16'h0070 + 16'(i), 16'($urandom), 16'($urandom), 3'b000, 2'b10,
                    16'h0300, 1'b0, 1'b0, 1'b0);
      advance();
      checkOutput("halt_pc", out_pc, 16'h0060);
      checkOutput("halt_flush", flush_out, 16'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
